// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
// Contents:
//   DEFAULT_WIDTH - default width of load_value and count
//   state_e       - controller states (IDLE, RUN, PAUSED)
package down_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter with pause, abort and a one-cycle expiry pulse.
//
// Optional feature: define DOWN_TIMER_AUTO_RELOAD_EN to keep the last
// accepted nonzero load value and restart from it on every expiry, so the
// timer keeps running until it is aborted or reset.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   load_valid in   request to start a countdown
//   load_ready out  high only in IDLE
//   load_value in   countdown start value (WIDTH bits)
//   pause      in   freeze the count while high
//   abort      in   cancel a countdown, back to IDLE without expiry
//   count      out  remaining count (registered)
//   busy       out  high in RUN or PAUSED
//   paused     out  high in PAUSED
//   expired    out  registered one-cycle pulse when the count reaches 0
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             expired
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             expired_q;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    // Controller state, count and expiry pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            expired_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // abort is irrelevant here; a zero load expires without running
                    if (load_valid) begin
                        if (load_value != '0) begin
                            count_q <= load_value;
                            state_q <= RUN;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                            reload_q <= load_value;
`endif
                        end else begin
                            expired_q <= 1'b1;
                        end
                    end
                end
                RUN, PAUSED: begin
                    // abort beats pause, which beats decrement
                    if (abort) begin
                        count_q <= '0;
                        state_q <= IDLE;
                    end else if (pause) begin
                        state_q <= PAUSED;
                    end else if (count_q == WIDTH'(1)) begin
                        expired_q <= 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        count_q   <= reload_q;
                        state_q   <= RUN;
`else
                        count_q   <= '0;
                        state_q   <= IDLE;
`endif
                    end else if (count_q != '0) begin
                        count_q <= count_q - WIDTH'(1);
                        state_q <= RUN;
                    end else begin
                        // unreachable in practice; never wrap below zero
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign count      = count_q;
    assign expired    = expired_q;
    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN) || (state_q == PAUSED);
    assign paused     = (state_q == PAUSED);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural reference model.
// Compile with DOWN_TIMER_AUTO_RELOAD_EN defined to exercise auto-reload.
module tb_down_timer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_value = '0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         paused;
    logic         expired;

    always #5 clk = ~clk;

    down_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .pause      (pause),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .paused     (paused),
        .expired    (expired)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining time, activity flags, and the pulse.
    int m_count  = 0;
    int m_reload = 0;
    bit m_busy   = 1'b0;
    bit m_paused = 1'b0;
    bit m_exp    = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        if (reset) begin
            m_count  = 0;
            m_reload = 0;
            m_busy   = 1'b0;
            m_paused = 1'b0;
            m_exp    = 1'b0;
        end else if (!m_busy) begin
            m_exp = 1'b0;
            if (load_valid) begin
                if (int'(load_value) != 0) begin
                    m_count  = int'(load_value);
                    m_reload = int'(load_value);
                    m_busy   = 1'b1;
                    m_paused = 1'b0;
                end else begin
                    m_exp = 1'b1;
                end
            end
        end else begin
            m_exp = 1'b0;
            if (abort) begin
                m_count  = 0;
                m_busy   = 1'b0;
                m_paused = 1'b0;
            end else if (pause) begin
                m_paused = 1'b1;
            end else begin
                m_paused = 1'b0;
                if (m_count > 0) m_count = m_count - 1;
                if (m_count == 0) begin
                    m_exp = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    m_count = m_reload;
`else
                    m_busy = 1'b0;
`endif
                end
            end
        end
    endtask

    // Drive inputs, take one edge, then compare every output with the model.
    task automatic cyc(input bit lv, input int lval, input bit pz, input bit ab, input bit rs);
        reset      = rs;
        load_valid = lv;
        load_value = W'(lval);
        pause      = pz;
        abort      = ab;
        @(posedge clk);
        model_step();
        #1;
        check_val("mdl_count",      32'(count),      32'(m_count));
        check_val("mdl_busy",       32'(busy),       32'(m_busy));
        check_val("mdl_paused",     32'(paused),     32'(m_paused));
        check_val("mdl_expired",    32'(expired),    32'(m_exp));
        check_val("mdl_load_ready", 32'(load_ready), 32'(!m_busy));
    endtask

    // Idle-input cycles until expired is seen or the bound runs out.
    task automatic run_to_expiry(input int limit, output int n);
        n = 0;
        do begin
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
            n++;
        end while (!expired && n < limit);
    endtask

    initial begin
        int n;

        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check_val("rst_count",      32'(count),      32'd0);
        check_val("rst_busy",       32'(busy),       32'd0);
        check_val("rst_paused",     32'(paused),     32'd0);
        check_val("rst_expired",    32'(expired),    32'd0);
        check_val("rst_load_ready", 32'(load_ready), 32'd1);

        // Zero load: no RUN, single pulse on the following cycle.
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
        check_val("z_busy",    32'(busy),    32'd0);
        check_val("z_expired", 32'(expired), 32'd1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("z_pulse_end", 32'(expired), 32'd0);

        // Abort in IDLE is ignored when a load is accepted.
        cyc(1'b1, 4, 1'b0, 1'b1, 1'b0);
        check_val("ia_busy",  32'(busy),  32'd1);
        check_val("ia_count", 32'(count), 32'd4);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check_val("ia_abort_busy", 32'(busy), 32'd0);

`ifndef DOWN_TIMER_AUTO_RELOAD_EN
        // Load 5: 4,3,2,1,0 then idle.
        cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
        check_val("l5_load", 32'(count), 32'd5);
        for (int v = 4; v >= 0; v--) begin
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
            check_val("l5_count", 32'(count), 32'(v));
        end
        check_val("l5_expired", 32'(expired), 32'd1);
        check_val("l5_busy",    32'(busy),    32'd0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("l5_pulse_end", 32'(expired), 32'd0);

        // Load 6 with a two-cycle pause at count 4.
        cyc(1'b1, 6, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("l6_at4", 32'(count), 32'd4);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
            check_val("l6_hold",   32'(count),  32'd4);
            check_val("l6_paused", 32'(paused), 32'd1);
        end
        run_to_expiry(20, n);
        check_val("l6_latency", 32'(n + 4), 32'd8);

        // Load 10, ignored load at count 8, abort at count 7.
        cyc(1'b1, 10, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("l10_at8", 32'(count), 32'd8);
        cyc(1'b1, 3, 1'b0, 1'b0, 1'b0);
        check_val("l10_ignored", 32'(count), 32'd7);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        check_val("l10_abort_count", 32'(count),   32'd0);
        check_val("l10_abort_busy",  32'(busy),    32'd0);
        check_val("l10_abort_exp",   32'(expired), 32'd0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("l10_no_exp", 32'(expired), 32'd0);

        // Load 255: full-range latency, no wrap.
        cyc(1'b1, 255, 1'b0, 1'b0, 1'b0);
        run_to_expiry(300, n);
        check_val("l255_latency", 32'(n), 32'd255);
        check_val("l255_count",   32'(count), 32'd0);
        check_val("l255_busy",    32'(busy),  32'd0);

        // Reset mid-countdown discards the count silently.
        cyc(1'b1, 9, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check_val("rmid_count", 32'(count),   32'd0);
        check_val("rmid_busy",  32'(busy),    32'd0);
        check_val("rmid_exp",   32'(expired), 32'd0);
`else
        // Load 3 with auto-reload: 2,1,3 with a pulse every third edge.
        cyc(1'b1, 3, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
            check_val("ar_c2", 32'(count), 32'd2);
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
            check_val("ar_c1", 32'(count), 32'd1);
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
            check_val("ar_reload",  32'(count),      32'd3);
            check_val("ar_expired", 32'(expired),    32'd1);
            check_val("ar_busy",    32'(busy),       32'd1);
            check_val("ar_ready",   32'(load_ready), 32'd0);
        end
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("ar_mid", 32'(count), 32'd2);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check_val("ar_rst_count", 32'(count),   32'd0);
        check_val("ar_rst_busy",  32'(busy),    32'd0);
        check_val("ar_rst_exp",   32'(expired), 32'd0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("ar_rst_no_exp", 32'(expired), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit lv, pz, ab, rs;
            int lval;
            lv   = ($urandom_range(0, 99) < 30);
            pz   = ($urandom_range(0, 99) < 25);
            ab   = ($urandom_range(0, 99) < 4);
            rs   = ($urandom_range(0, 99) < 2);
            lval = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 8));
            cyc(lv, lval, pz, ab, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter WIDTH, default 8, bit width of load_value and count.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 load_valid  input  1  request to start a countdown with load_value.
REQ-005 load_ready  output  1  block can accept a load this cycle.
REQ-006 load_value  input  WIDTH  countdown start value.
REQ-007 pause  input  1  freeze count while high.
REQ-008 abort  input  1  cancel countdown, return to idle.
REQ-009 count  output  WIDTH  current remaining count, registered.
REQ-010 busy  output  1  high in RUN or PAUSED.
REQ-011 paused  output  1  high in PAUSED.
REQ-012 expired  output  1  registered one-cycle pulse when count reaches 0 by decrement.

Function
REQ-013 States SHALL be IDLE, RUN, PAUSED; busy and paused decode directly from state.
REQ-014 load_ready SHALL be 1 only in IDLE; load accepted on an edge where load_valid && load_ready.
REQ-015 On accept with load_value != 0: count <= load_value, state <= RUN, expired <= 0.
REQ-016 On accept with load_value == 0: count stays 0, state stays IDLE, expired pulses on the following cycle (count 0 -> pulse, no RUN).
REQ-017 In RUN or PAUSED, each edge with pause low and abort low: count <= count - 1, state <= RUN.
REQ-018 In RUN or PAUSED, each edge with pause high and abort low: count holds, state <= PAUSED.
REQ-019 Decrement from 1 to 0: expired high for exactly the next cycle, state <= IDLE (or reload per REQ-027).
REQ-020 Latency: load of V (V>0) accepted at edge N with pause low throughout -> expired high in the cycle after edge N+V.
REQ-021 abort in RUN/PAUSED: count <= 0, state <= IDLE, no expired pulse; abort wins over pause and decrement-to-zero on the same edge.
REQ-022 abort in IDLE: no effect; load in the same cycle is still accepted (abort ignored when load accepted).
REQ-023 count SHALL never wrap below 0; decrement only occurs when count > 0.
REQ-024 load_valid while busy is ignored; no state change, no buffering.

Reset
REQ-025 reset SHALL override all inputs: state IDLE, count 0, expired 0, busy 0, paused 0, load_ready 1 after the edge.
REQ-026 reset mid-countdown SHALL discard the count with no expired pulse.

Configuration
REQ-027 With DOWN_TIMER_AUTO_RELOAD_EN defined: last accepted nonzero load_value SHALL be stored; on decrement to 0, expired pulses, count <= stored value, state stays RUN; only abort or reset exits; load_ready stays 0.
REQ-028 Without DOWN_TIMER_AUTO_RELOAD_EN: no reload register, behaviour per REQ-019; zero-value loads never auto-reload in either build.

Structure
REQ-029 Package down_timer_pkg SHALL hold the state enum typedef (IDLE, RUN, PAUSED) and DEFAULT_WIDTH = 8.
REQ-030 Single module; no sub-module needed; state, count and optional reload register in one always_ff, outputs decoded combinationally from state.

Verification
REQ-031 Bench clock period 10 ns; reset high 3 cycles, then checks start.
REQ-032 Load 5, pause low -> count 4,3,2,1,0 on successive edges; expired high one cycle after count 0 edge, busy low afterward.
REQ-033 Load 6, pause high 2 cycles after count reaches 4 -> count holds 4 two cycles, paused 1; expired 8 cycles after accept.
REQ-034 Load 10, abort at count 7 -> count 0, busy 0, no expired; load_valid while busy at count 8 ignored.
REQ-035 Load 0 -> no RUN, expired pulses once next cycle; load 255 (WIDTH 8) -> expired after 255 cycles, no wrap.
REQ-036 AUTO_RELOAD build, load 3 -> expired every 3 cycles for 4 periods, count 2,1,0->3 pattern; reset mid-count 2 -> count 0, IDLE, no expired.
